lcd_timing_gen: RTL

- Pixel-clock-domain LCD timing generator, directly downstream of the LCD FIFO read controller.
- Produces HS/VS/DE and the one-cycle-early data request (lcd_data_requst) that drives FIFO reads.
- Captures FIFO read data onto the RGB bus and flags underflow when a requested pixel was not read.
- Outputs pixel coordinates for overlay logic.

---
 rtl/lcd_pkg.sv | 26 ++
 rtl/lcd_scan_cnt.sv | 65 ++++++
 rtl/lcd_timing_gen.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD timing generator.
//   - Default 480x272 panel timing (pixel clocks / lines).
//   - Scan counter width.
//   - FSM state encoding.
package lcd_pkg;

    // Scan counter width. The sum of all timing parameters must fit, i.e. <= 2047.
    localparam int unsigned CNT_W = 11;

    localparam int unsigned DEF_H_SYNC  = 41;
    localparam int unsigned DEF_H_BACK  = 2;
    localparam int unsigned DEF_H_DISP  = 480;
    localparam int unsigned DEF_H_FRONT = 2;
    localparam int unsigned DEF_V_SYNC  = 10;
    localparam int unsigned DEF_V_BACK  = 2;
    localparam int unsigned DEF_V_DISP  = 272;
    localparam int unsigned DEF_V_FRONT = 2;
    localparam int unsigned DEF_DATA_W  = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StStop = 2'd2
    } lcd_state_e;

endpackage

// File: rtl/lcd_scan_cnt.sv
// Horizontal/vertical scan counter pair.
//   lcd_clk   : pixel clock
//   rst_n     : asynchronous active-low reset
//   clr       : synchronous clear of both counters
//   adv       : advance one pixel position
//   h_cnt     : column position, wraps H_TOTAL-1 -> 0
//   v_cnt     : line position, advances on each h wrap, wraps V_TOTAL-1 -> 0
//   line_end  : h_cnt is at H_TOTAL-1
//   last_line : v_cnt is at V_TOTAL-1
module lcd_scan_cnt
    import lcd_pkg::*;
#(
    parameter int unsigned H_TOTAL = 525,
    parameter int unsigned V_TOTAL = 286
) (
    input  logic             lcd_clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adv,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             line_end,
    output logic             last_line
);

    localparam logic [CNT_W-1:0] HLast  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] VLast  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

    assign line_end  = (h_cnt_q == HLast);
    assign last_line = (v_cnt_q == VLast);

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (clr) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (adv) begin
            if (line_end) begin
                h_cnt_d = '0;
                v_cnt_d = last_line ? '0 : v_cnt_q + CntOne;
            end else begin
                h_cnt_d = h_cnt_q + CntOne;
            end
        end
    end

    always_ff @(posedge lcd_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt = h_cnt_q;
    assign v_cnt = v_cnt_q;

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD timing generator in the pixel clock domain.
//   lcd_clk         : pixel clock (FIFO read clock)
//   rst_n           : asynchronous active-low reset
//   en              : run request, level-sensitive
//   fifo_rd_en      : FIFO read strobe actually issued by the read controller
//   fifo_rd_data    : FIFO data, valid one cycle after fifo_rd_en
//   lcd_data_requst : pixel request, one cycle ahead of each DE cycle
//   lcd_hs/lcd_vs   : active-low syncs
//   lcd_de          : data enable
//   lcd_rgb         : pixel data (0 outside DE or on a missed read)
//   lcd_x/lcd_y     : active column/row
//   frame_start     : one-cycle pulse for position h=0, v=0 while running
//   underflow       : sticky, set when a DE cycle had no read; cleared at frame_start
module lcd_timing_gen
    import lcd_pkg::*;
#(
    parameter int unsigned H_SYNC  = DEF_H_SYNC,
    parameter int unsigned H_BACK  = DEF_H_BACK,
    parameter int unsigned H_DISP  = DEF_H_DISP,
    parameter int unsigned H_FRONT = DEF_H_FRONT,
    parameter int unsigned V_SYNC  = DEF_V_SYNC,
    parameter int unsigned V_BACK  = DEF_V_BACK,
    parameter int unsigned V_DISP  = DEF_V_DISP,
    parameter int unsigned V_FRONT = DEF_V_FRONT,
    parameter int unsigned DATA_W  = DEF_DATA_W
) (
    input  logic              lcd_clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              lcd_data_requst,
    output logic              lcd_hs,
    output logic              lcd_vs,
    output logic              lcd_de,
    output logic [DATA_W-1:0] lcd_rgb,
    output logic [CNT_W-1:0]  lcd_x,
    output logic [CNT_W-1:0]  lcd_y,
    output logic              frame_start,
    output logic              underflow
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam logic [CNT_W-1:0] HSyncEnd = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] VSyncEnd = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] Hsa      = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] HdeEnd   = CNT_W'(H_SYNC + H_BACK + H_DISP);
    localparam logic [CNT_W-1:0] Vsa      = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] VdeEnd   = CNT_W'(V_SYNC + V_BACK + V_DISP);
    // Request window is the DE window shifted one column earlier.
    localparam logic [CNT_W-1:0] ReqStart = CNT_W'(H_SYNC + H_BACK - 1);
    localparam logic [CNT_W-1:0] ReqEnd   = CNT_W'(H_SYNC + H_BACK + H_DISP - 1);

    lcd_state_e state_q, state_d;

    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             line_end, last_line, frame_end;
    logic             scanning;

    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              de_q, de_d;
    logic              req_q, req_d;
    logic [CNT_W-1:0]  x_q, x_d;
    logic [CNT_W-1:0]  y_q, y_d;
    logic              fs_q, fs_d;
    logic              rd_ok_q;
    logic              uf_q, uf_d;
    logic              h_in_de, h_in_req, v_in_de;

    assign scanning  = (state_q != StIdle);
    assign frame_end = line_end && last_line;

    lcd_scan_cnt #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_scan_cnt (
        .lcd_clk   (lcd_clk),
        .rst_n     (rst_n),
        .clr       (!scanning),
        .adv       (scanning),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .line_end  (line_end),
        .last_line (last_line)
    );

    // STOP keeps scanning so the frame in flight always completes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (en) state_d = StRun;
            StRun:   if (!en) state_d = StStop;
            StStop: begin
                if (en) begin
                    state_d = StRun;
                end else if (frame_end) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Counter decode; everything lands in registers one cycle later.
    always_comb begin
        h_in_de  = (h_cnt >= Hsa) && (h_cnt < HdeEnd);
        h_in_req = (h_cnt >= ReqStart) && (h_cnt < ReqEnd);
        v_in_de  = (v_cnt >= Vsa) && (v_cnt < VdeEnd);

        hs_d  = 1'b1;
        vs_d  = 1'b1;
        de_d  = 1'b0;
        req_d = 1'b0;
        x_d   = '0;
        y_d   = '0;
        fs_d  = 1'b0;
        if (scanning) begin
            hs_d  = (h_cnt >= HSyncEnd);
            vs_d  = (v_cnt >= VSyncEnd);
            de_d  = h_in_de && v_in_de;
            req_d = h_in_req && v_in_de;
            if (de_d) x_d = h_cnt - Hsa;
            if (v_in_de) y_d = v_cnt - Vsa;
            fs_d  = (state_q == StRun) && (h_cnt == '0) && (v_cnt == '0);
        end

        // A missed read in the same cycle as the frame_start clear still sets.
        uf_d = uf_q;
        if (de_q && !rd_ok_q) begin
            uf_d = 1'b1;
        end else if (fs_q || !scanning) begin
            uf_d = 1'b0;
        end
    end

    always_ff @(posedge lcd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            de_q    <= 1'b0;
            req_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            fs_q    <= 1'b0;
            rd_ok_q <= 1'b0;
            uf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            req_q   <= req_d;
            x_q     <= x_d;
            y_q     <= y_d;
            fs_q    <= fs_d;
            rd_ok_q <= fifo_rd_en;
            uf_q    <= uf_d;
        end
    end

    assign lcd_hs          = hs_q;
    assign lcd_vs          = vs_q;
    assign lcd_de          = de_q;
    assign lcd_data_requst = req_q;
    assign lcd_x           = x_q;
    assign lcd_y           = y_q;
    assign frame_start     = fs_q;
    assign underflow       = uf_q;
    // FIFO data arrives the cycle after the read, which is the DE cycle itself.
    assign lcd_rgb         = (de_q && rd_ok_q) ? fifo_rd_data : '0;

endmodule
